// File: rtl/sys_cmd_framer_if.sv
// Command, TX byte stream, RX byte strobe and response bundle for sys_cmd_framer.
// The master side is the host/requester; the slave side is the framer itself.
interface sys_cmd_framer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int Addr_SIZE  = 4
);
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [1:0]              cmd_type;
   logic [Addr_SIZE-1:0]    cmd_addr;
   logic [DATA_WIDTH-1:0]   cmd_op_a;
   logic [DATA_WIDTH-1:0]   cmd_op_b;
   logic [3:0]              cmd_fun;
   logic [DATA_WIDTH-1:0]   tx_byte;
   logic                    tx_valid;
   logic                    tx_ready;
   logic [DATA_WIDTH-1:0]   rx_byte;
   logic                    rx_valid;
   logic [2*DATA_WIDTH-1:0] rsp_data;
   logic                    rsp_valid;
   logic                    rsp_err;

   modport master (
      output cmd_valid, cmd_type, cmd_addr, cmd_op_a, cmd_op_b, cmd_fun,
      output tx_ready, rx_byte, rx_valid,
      input  cmd_ready, tx_byte, tx_valid, rsp_data, rsp_valid, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_type, cmd_addr, cmd_op_a, cmd_op_b, cmd_fun,
      input  tx_ready, rx_byte, rx_valid,
      output cmd_ready, tx_byte, tx_valid, rsp_data, rsp_valid, rsp_err
   );
endinterface

// File: rtl/sys_cmd_framer.sv
// Host-side command framer: serialises one command into a byte frame for the
// UART TX, then collects the response bytes from the UART RX or times out.
module sys_cmd_framer #(
   parameter int DATA_WIDTH  = 8,
   parameter int Addr_SIZE   = 4,
   parameter int TIMEOUT_CYC = 4095
) (
   input logic             CLK,
   input logic             RST,
   sys_cmd_framer_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]         TO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [DATA_WIDTH-1:0] HDR_WR  = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] HDR_RD  = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] HDR_ALU = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] HDR_NOP = DATA_WIDTH'(8'hDD);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} state_t;
   typedef enum logic [1:0] {RF_WR, RF_RD, ALU_W_OP, ALU_NO_OP} cmd_t;

   state_t                  state, state_nxt;
   cmd_t                    type_q;
   logic [Addr_SIZE-1:0]    addr_q;
   logic [DATA_WIDTH-1:0]   op_a_q, op_b_q;
   logic [3:0]              fun_q;
   logic [1:0]              idx_q;
   logic                    rx_cnt_q;
   logic [TW-1:0]           timer_q;
   logic [2*DATA_WIDTH-1:0] rsp_data_q;
   logic                    rsp_valid_q, rsp_err_q;

   logic [DATA_WIDTH-1:0]   frame_byte;
   logic [1:0]              last_idx;
   logic                    cmd_ready, tx_valid;
   logic [DATA_WIDTH-1:0]   tx_byte;
   logic                    tx_fire, last_tx, rx_take, last_rx, timed_out;

   assign tx_fire   = (state == SEND) && bus.tx_ready;
   assign last_tx   = (idx_q == last_idx);
   assign rx_take   = (state == WAIT_RSP) && bus.rx_valid;
   assign last_rx   = (type_q == RF_RD) || rx_cnt_q;
   // A byte arriving in the expiry cycle takes priority over the timeout.
   assign timed_out = (state == WAIT_RSP) && !bus.rx_valid && (timer_q >= TO_LAST);

   always_comb begin
      frame_byte = '0;
      last_idx   = 2'd1;
      case (type_q)
         RF_WR: begin
            last_idx = 2'd2;
            case (idx_q)
               2'd0:    frame_byte = HDR_WR;
               2'd1:    frame_byte = DATA_WIDTH'(addr_q);
               default: frame_byte = op_a_q;
            endcase
         end
         RF_RD:     frame_byte = (idx_q == 2'd0) ? HDR_RD : DATA_WIDTH'(addr_q);
         ALU_W_OP: begin
            last_idx = 2'd3;
            case (idx_q)
               2'd0:    frame_byte = HDR_ALU;
               2'd1:    frame_byte = op_a_q;
               2'd2:    frame_byte = op_b_q;
               default: frame_byte = DATA_WIDTH'(fun_q);
            endcase
         end
         default:   frame_byte = (idx_q == 2'd0) ? HDR_NOP : DATA_WIDTH'(fun_q);
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      tx_valid  = 1'b0;
      tx_byte   = '0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (bus.cmd_valid) state_nxt = SEND;
         end
         SEND: begin
            tx_valid = 1'b1;
            tx_byte  = frame_byte;
            if (tx_fire && last_tx) state_nxt = (type_q == RF_WR) ? IDLE : WAIT_RSP;
         end
         WAIT_RSP: begin
            if (rx_take ? last_rx : timed_out) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // timer_q counts cycles waited since the last restart, so the registered
   // timeout pulse lands TIMEOUT_CYC cycles after that restart.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         type_q      <= RF_WR;
         addr_q      <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         fun_q       <= '0;
         idx_q       <= '0;
         rx_cnt_q    <= 1'b0;
         timer_q     <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  type_q     <= cmd_t'(bus.cmd_type);
                  addr_q     <= bus.cmd_addr;
                  op_a_q     <= bus.cmd_op_a;
                  op_b_q     <= bus.cmd_op_b;
                  fun_q      <= bus.cmd_fun;
                  idx_q      <= '0;
                  rsp_data_q <= '0;
               end
            end
            SEND: begin
               if (tx_fire) begin
                  idx_q <= idx_q + 2'd1;
                  if (last_tx) begin
                     rx_cnt_q <= 1'b0;
                     timer_q  <= TW'(1);
                     if (type_q == RF_WR) rsp_valid_q <= 1'b1;
                  end
               end
            end
            WAIT_RSP: begin
               if (rx_take) begin
                  if (rx_cnt_q) rsp_data_q[2*DATA_WIDTH-1:DATA_WIDTH] <= bus.rx_byte;
                  else          rsp_data_q[DATA_WIDTH-1:0]            <= bus.rx_byte;
                  rx_cnt_q <= 1'b1;
                  timer_q  <= TW'(1);
                  if (last_rx) rsp_valid_q <= 1'b1;
               end else if (timed_out) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.tx_valid  = tx_valid;
   assign bus.tx_byte   = tx_byte;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_sys_cmd_framer.sv
// Bench for sys_cmd_framer: directed and random commands checked against a
// frame/response model built from the command table and timeout rule.
module tb_sys_cmd_framer;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int TO = 16;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   sys_cmd_framer_if #(.DATA_WIDTH(DW), .Addr_SIZE(AW)) bus();
   sys_cmd_framer #(.DATA_WIDTH(DW), .Addr_SIZE(AW), .TIMEOUT_CYC(TO)) dut (
      .CLK(CLK), .RST(RST), .bus(bus)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   logic [7:0]  tx_q[$];
   int          tx_cq[$];
   logic [15:0] rsp_dq[$];
   logic        rsp_eq[$];
   logic        rsp_rq[$];
   int          rsp_cq[$];
   int          acc_q[$];
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_byte = 8'h00;

   logic [7:0]  exp_frame[4];
   int          exp_len, exp_rlen;
   logic [7:0]  rx_bytes[2];
   int          rx_gap[2];
   int          n_rx;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Monitor: handshakes sampled mid-cycle complete on the following edge.
   always @(negedge CLK) begin
      if (RST) begin
         if (prev_stall) begin
            chk("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
            chk("tx_hold_byte", 32'(bus.tx_byte), 32'(prev_byte));
         end
         if (bus.tx_valid && bus.tx_ready) begin
            tx_q.push_back(bus.tx_byte);
            tx_cq.push_back(cyc);
         end
         if (bus.rsp_valid) begin
            rsp_dq.push_back(bus.rsp_data);
            rsp_eq.push_back(bus.rsp_err);
            rsp_rq.push_back(bus.cmd_ready);
            rsp_cq.push_back(cyc);
         end
         if (bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc);
         prev_stall <= bus.tx_valid && !bus.tx_ready;
         prev_byte  <= bus.tx_byte;
      end else begin
         prev_stall <= 1'b0;
      end
   end

   function automatic void build_model(input logic [1:0] typ, input logic [3:0] addr,
                                       input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] fun);
      exp_frame[0] = 8'h00; exp_frame[1] = 8'h00; exp_frame[2] = 8'h00; exp_frame[3] = 8'h00;
      case (typ)
         2'd0: begin exp_frame[0] = 8'hAA; exp_frame[1] = {4'h0, addr}; exp_frame[2] = a; exp_len = 3; exp_rlen = 0; end
         2'd1: begin exp_frame[0] = 8'hBB; exp_frame[1] = {4'h0, addr}; exp_len = 2; exp_rlen = 1; end
         2'd2: begin exp_frame[0] = 8'hCC; exp_frame[1] = a; exp_frame[2] = b; exp_frame[3] = {4'h0, fun};
                     exp_len = 4; exp_rlen = 2; end
         default: begin exp_frame[0] = 8'hDD; exp_frame[1] = {4'h0, fun}; exp_len = 2; exp_rlen = 2; end
      endcase
   endfunction

   // mode: 0 tx_ready held high, 1 toggling starting low, 2 random.
   task automatic run_cmd(input logic [1:0] typ, input logic [3:0] addr, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] fun, input int mode, input bit hold);
      int t0, r0, ac, ev, k, e, got, ecyc;
      logic [15:0] ed;
      logic ee;
      build_model(typ, addr, a, b, fun);
      t0 = tx_q.size();
      r0 = rsp_dq.size();
      for (int w = 0; w < 50 && !bus.cmd_ready; w++) step();
      chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_type = typ; bus.cmd_addr = addr; bus.cmd_op_a = a; bus.cmd_op_b = b; bus.cmd_fun = fun;
      bus.cmd_valid = 1'b1;
      ac = cyc;
      step();
      if (!hold) bus.cmd_valid = 1'b0;
      ev = -1;
      k = 0;
      for (int c = 0; c < 400 && rsp_dq.size() == r0; c++) begin
         case (mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = (c % 2 == 1);
            default: bus.tx_ready = 1'($urandom_range(0, 1));
         endcase
         bus.rx_valid = 1'b0;
         if (ev < 0 && tx_q.size() - t0 >= exp_len) ev = tx_cq[tx_cq.size() - 1];
         if (ev >= 0 && k < n_rx && cyc - ev == rx_gap[k]) begin
            bus.rx_valid = 1'b1;
            bus.rx_byte  = rx_bytes[k];
            ev = cyc;
            k++;
         end
         step();
      end
      bus.rx_valid = 1'b0;
      chk("rsp_seen", 32'(rsp_dq.size() - r0), 32'd1);
      chk("tx_count", 32'(tx_q.size() - t0), 32'(exp_len));
      for (int i = 0; i < exp_len; i++) begin
         if (t0 + i < tx_q.size()) begin
            chk($sformatf("frame_byte%0d", i), 32'(tx_q[t0 + i]), 32'(exp_frame[i]));
            if (mode == 0) chk($sformatf("frame_cycle%0d", i), 32'(tx_cq[t0 + i]), 32'(ac + 1 + i));
         end
      end
      if (tx_cq.size() >= t0 + exp_len && rsp_dq.size() > r0) begin
         e = tx_cq[t0 + exp_len - 1];
         ed = 16'h0000;
         ee = 1'b0;
         got = 0;
         for (int j = 0; j < n_rx && got < exp_rlen; j++) begin
            if (rx_gap[j] > TO - 1) break;
            e += rx_gap[j];
            ed[8*got +: 8] = rx_bytes[j];
            got++;
         end
         if (got == exp_rlen) ecyc = e + 1;
         else begin ee = 1'b1; ecyc = e + TO; end
         chk("rsp_data", 32'(rsp_dq[r0]), 32'(ed));
         chk("rsp_err", 32'(rsp_eq[r0]), 32'(ee));
         chk("rsp_cycle", 32'(rsp_cq[r0]), 32'(ecyc));
         chk("rsp_cmd_ready", 32'(rsp_rq[r0]), 32'd1);
      end
      @(negedge CLK);
      chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int r0, n0, a0, w;
      bus.cmd_valid = 1'b0; bus.cmd_type = 2'd0; bus.cmd_addr = '0; bus.cmd_op_a = '0;
      bus.cmd_op_b = '0; bus.cmd_fun = '0; bus.tx_ready = 1'b0; bus.rx_byte = '0; bus.rx_valid = 1'b0;
      n_rx = 0;
      repeat (3) step();
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("rst_tx_byte", 32'(bus.tx_byte), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      RST = 1'b1;
      step();

      n_rx = 0;
      run_cmd(2'd0, 4'd5, 8'h3C, 8'h00, 4'd0, 0, 1'b0);
      n_rx = 1; rx_bytes[0] = 8'h7E; rx_gap[0] = 2;
      run_cmd(2'd1, 4'd2, 8'h00, 8'h00, 4'd0, 0, 1'b0);
      n_rx = 2; rx_bytes[0] = 8'h00; rx_gap[0] = 3; rx_bytes[1] = 8'h02; rx_gap[1] = 1;
      run_cmd(2'd2, 4'd0, 8'h10, 8'h20, 4'd2, 1, 1'b0);
      n_rx = 1; rx_bytes[0] = 8'h55; rx_gap[0] = 4;
      run_cmd(2'd3, 4'd0, 8'h00, 8'h00, 4'd7, 0, 1'b0);
      n_rx = 2; rx_bytes[0] = 8'h11; rx_gap[0] = TO - 1; rx_bytes[1] = 8'h22; rx_gap[1] = TO - 1;
      run_cmd(2'd3, 4'd0, 8'h00, 8'h00, 4'd9, 0, 1'b0);
      n_rx = 0;
      run_cmd(2'd1, 4'd15, 8'h00, 8'h00, 4'd0, 0, 1'b0);

      r0 = rsp_dq.size();
      bus.rx_valid = 1'b1; bus.rx_byte = 8'h99;
      step();
      bus.rx_valid = 1'b0;
      repeat (5) step();
      chk("stray_rx_no_rsp", 32'(rsp_dq.size() - r0), 32'd0);
      chk("stray_rx_idle", 32'(bus.cmd_ready), 32'd1);

      a0 = acc_q.size();
      n_rx = 0;
      run_cmd(2'd0, 4'd9, 8'h5A, 8'h00, 4'd0, 0, 1'b1);
      bus.cmd_valid = 1'b0;
      chk("hold_accepts", 32'(acc_q.size() - a0), 32'd2);
      if (acc_q.size() - a0 >= 2)
         chk("hold_second_accept", 32'(acc_q[a0 + 1]), 32'(rsp_cq[rsp_cq.size() - 1]));
      r0 = rsp_dq.size();
      for (w = 0; w < 20 && rsp_dq.size() == r0; w++) step();
      chk("hold_second_rsp", 32'(rsp_dq.size() - r0), 32'd1);
      if (tx_q.size() >= 3) begin
         chk("hold_second_b0", 32'(tx_q[tx_q.size() - 3]), 32'hAA);
         chk("hold_second_b2", 32'(tx_q[tx_q.size() - 1]), 32'h5A);
      end
      repeat (2) step();

      bus.tx_ready = 1'b1;
      bus.cmd_type = 2'd2; bus.cmd_op_a = 8'h66; bus.cmd_op_b = 8'h77; bus.cmd_fun = 4'd3;
      bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      n0 = tx_q.size();
      r0 = rsp_dq.size();
      step();
      chk("midrst_byte1", 32'(bus.tx_byte), 32'h66);
      RST = 1'b0;
      #1;
      chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("midrst_tx_byte", 32'(bus.tx_byte), 32'd0);
      repeat (2) step();
      RST = 1'b1;
      repeat (20) step();
      chk("midrst_tx_bytes", 32'(tx_q.size() - n0), 32'd1);
      chk("midrst_no_rsp", 32'(rsp_dq.size() - r0), 32'd0);
      n_rx = 2; rx_bytes[0] = 8'hA1; rx_gap[0] = 1; rx_bytes[1] = 8'hB2; rx_gap[1] = 2;
      run_cmd(2'd2, 4'd0, 8'h01, 8'h02, 4'd4, 0, 1'b0);

      for (int n = 0; n < 20; n++) begin
         logic [1:0] typ;
         typ = 2'($urandom_range(0, 3));
         build_model(typ, 4'd0, 8'h00, 8'h00, 4'd0);
         n_rx = (exp_rlen == 0) ? 0 : int'($urandom_range(0, exp_rlen));
         if (exp_rlen != 0 && $urandom_range(0, 2) != 0) n_rx = exp_rlen;
         for (int j = 0; j < 2; j++) begin
            rx_bytes[j] = 8'($urandom);
            rx_gap[j]   = int'($urandom_range(1, TO + 2));
         end
         run_cmd(typ, 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), int'($urandom_range(0, 2)), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sys_cmd_framer.md
Name: sys_cmd_framer

Overview:
- Host-side command framer/response collector for the UART-controlled system; sits directly upstream of the system's serial RX input.
- Accepts one parallel command request and emits its byte frame through a valid/ready byte stream to a UART transmitter.
- Collects the response bytes from a UART receiver and reports the response or a timeout.
- Blocks new commands until the current one completes.

Parameters:
- DATA_WIDTH, 8: byte width of frame bytes, operands and response bytes.
- Addr_SIZE, 4: register-file address width; zero-extended to DATA_WIDTH in the frame.
- TIMEOUT_CYC, 4095: max CLK cycles waited for each response byte; counter width is clog2(TIMEOUT_CYC+1).

Ports:
- CLK  in  1  single clock.
- RST  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  framer can accept a command.
- cmd_type  in  2  0=RF_WR, 1=RF_RD, 2=ALU_W_OP, 3=ALU_NO_OP.
- cmd_addr  in  Addr_SIZE  register address.
- cmd_op_a  in  DATA_WIDTH  write data (RF_WR) or operand A.
- cmd_op_b  in  DATA_WIDTH  operand B.
- cmd_fun  in  4  ALU function.
- tx_byte  out  DATA_WIDTH  frame byte to UART TX.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  UART TX accepts byte.
- rx_byte  in  DATA_WIDTH  byte from UART RX.
- rx_valid  in  1  single-cycle strobe for rx_byte.
- rsp_data  out  2*DATA_WIDTH  collected response.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout.

Behaviour:
- Frames, bytes in send order:
  - RF_WR: 0xAA, addr, op_a.
  - RF_RD: 0xBB, addr.
  - ALU_W_OP: 0xCC, op_a, op_b, fun.
  - ALU_NO_OP: 0xDD, fun.
  - addr and fun are zero-extended to DATA_WIDTH.
- Expected response length: RF_WR 0, RF_RD 1, ALU 2.
- States: IDLE, SEND, WAIT_RSP. State is registered; RST low forces IDLE immediately.
- IDLE:
  - cmd_ready=1 (combinational on state==IDLE, so 1 right after reset).
  - On cmd_valid, latch all cmd_* fields, clear byte index, clear rsp_data, go to SEND.
- SEND:
  - tx_valid=1 from the cycle after acceptance; tx_byte=frame[idx].
  - tx_byte is held stable while tx_valid && !tx_ready.
  - Each tx_valid&&tx_ready advances idx. tx_valid never drops before acceptance.
  - On the last byte accepted:
    - length 0: pulse rsp_valid (rsp_err=0, rsp_data=0) next cycle, go to IDLE.
    - otherwise: clear rx count and timer, go to WAIT_RSP.
- WAIT_RSP:
  - Each rx_valid stores a byte: first byte to rsp_data[7:0], second to [15:8] (LSB first). Unused bits stay 0.
  - Timer restarts on each rx_valid.
  - After the final expected byte: rsp_valid=1, rsp_err=0 the next cycle, go to IDLE.
  - If the timer reaches TIMEOUT_CYC first: rsp_valid=1, rsp_err=1, rsp_data holds the partial bytes, go to IDLE.
  - If rx_valid arrives in the same cycle the timer expires, the byte wins; the timer is not flagged.
- rx_valid in IDLE or SEND is ignored: no state change, no data capture.
- cmd_valid outside IDLE is ignored; cmd_ready=0.
- rsp_valid is exactly one cycle. cmd_ready returns to 1 in the same cycle rsp_valid is high.
- Reset values: tx_byte=0, tx_valid=0, rsp_data=0, rsp_valid=0, rsp_err=0, all counters 0.
- Reset mid-frame or mid-wait aborts silently: no rsp_valid and no further tx bytes.
- Throughput: with tx_ready held at 1, an N-byte frame occupies N consecutive cycles.

Test Plan:
- RF_WR addr=5, op_a=0x3C, tx_ready=1 -> tx bytes 0xAA,0x05,0x3C on 3 consecutive cycles; rsp_valid 1 cycle later with rsp_err=0, rsp_data=0.
- RF_RD addr=2, then rx_byte=0x7E -> tx bytes 0xBB,0x02; rsp_data=0x007E, rsp_valid 1 cycle after rx_valid.
- ALU_W_OP A=0x10, B=0x20, fun=2, with tx_ready toggling 1/0 -> bytes 0xCC,0x10,0x20,0x02 each held stable until accepted; rx 0x00 then 0x02 -> rsp_data=0x0200.
- ALU_NO_OP with only one rx byte 0x55, TIMEOUT_CYC=16 -> rsp_valid and rsp_err=1 exactly 16 cycles after that byte; rsp_data=0x0055.
- cmd_valid held during SEND, plus stray rx_valid in IDLE -> second command not accepted until after rsp_valid; stray byte causes no response.
- RST low during the 2nd byte of an ALU_W_OP frame -> tx_valid=0 and state IDLE immediately; no rsp_valid; next command framed correctly.
